// File: rtl/bombman_pkg.sv
// Shared definitions for the BombMan display path: cell codes, game-over
// encoding, default 640x480 timing and the cell-code palette.
package bombman_pkg;

    // Cell codes stored in the game-state memory
    localparam logic [2:0] CELL_BG        = 3'd0;
    localparam logic [2:0] CELL_BLOCK     = 3'd1;
    localparam logic [2:0] CELL_P1        = 3'd2;
    localparam logic [2:0] CELL_P2        = 3'd3;
    localparam logic [2:0] CELL_BOMB_NEW  = 3'd4;
    localparam logic [2:0] CELL_BOMB_AGED = 3'd5;
    localparam logic [2:0] CELL_EXPLODE   = 3'd6;
    localparam logic [2:0] CELL_RSVD      = 3'd7;

    // game_over encoding
    localparam logic [1:0] GO_PLAYING = 2'd0;
    localparam logic [1:0] GO_P1_WIN  = 2'd1;
    localparam logic [1:0] GO_P2_WIN  = 2'd2;
    localparam logic [1:0] GO_DRAW    = 2'd3;

    // Default 640x480 @ 60 Hz timing (25 MHz pixel clock)
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 29;

    // Packed colours {R[2:0], G[2:0], B[1:0]}
    localparam logic [7:0] RGB_BLACK = 8'b000_000_00;
    localparam logic [7:0] RGB_WHITE = 8'b111_111_11;
    localparam logic [7:0] RGB_RED   = 8'b111_000_00;
    localparam logic [7:0] RGB_BLUE  = 8'b000_000_11;

    // Cell code to packed colour; the reserved code renders black
    function automatic logic [7:0] palette_rgb(input logic [2:0] code);
        logic [7:0] rgb;
        case (code)
            CELL_BG:        rgb = {3'd7, 3'd7, 2'd3};
            CELL_BLOCK:     rgb = {3'd6, 3'd7, 2'd3};
            CELL_P1:        rgb = {3'd5, 3'd7, 2'd3};
            CELL_P2:        rgb = {3'd4, 3'd7, 2'd3};
            CELL_BOMB_NEW:  rgb = {3'd3, 3'd7, 2'd3};
            CELL_BOMB_AGED: rgb = {3'd2, 3'd7, 2'd3};
            CELL_EXPLODE:   rgb = {3'd1, 3'd7, 2'd3};
            default:        rgb = RGB_BLACK;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters for the VGA display: owns hc/vc and derives the raw
// (undelayed) sync, visible-area and line/frame boundary strobes.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 29,
    parameter int HC_W     = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VC_W     = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic pixel_clk_i,
    input  logic rst_i,
    output logic hsync_raw_o,
    output logic vsync_raw_o,
    output logic active_raw_o,
    output logic line_end_o,
    output logic frame_end_o,
    output logic origin_o
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    logic [HC_W-1:0] hc_q, hc_d;
    logic [VC_W-1:0] vc_q, vc_d;
    logic            last_line;

    assign line_end_o   = (hc_q == HC_W'(H_TOTAL - 1));
    assign last_line    = (vc_q == VC_W'(V_TOTAL - 1));
    assign frame_end_o  = line_end_o && last_line;
    assign origin_o     = (hc_q == '0) && (vc_q == '0);
    assign active_raw_o = (int'(hc_q) < H_ACTIVE) && (int'(vc_q) < V_ACTIVE);
    assign hsync_raw_o  = !((int'(hc_q) >= HS_START) && (int'(hc_q) < HS_END));
    assign vsync_raw_o  = !((int'(vc_q) >= VS_START) && (int'(vc_q) < VS_END));

    // Next raster position: hc wraps each line, vc advances on hc wrap
    always_comb begin
        hc_d = hc_q + HC_W'(1);
        vc_d = vc_q;
        if (line_end_o) begin
            hc_d = '0;
            vc_d = last_line ? '0 : vc_q + VC_W'(1);
        end
    end

    // Raster counter registers, restart at the origin on reset
    always_ff @(posedge pixel_clk_i or posedge rst_i) begin
        if (rst_i) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

endmodule

// File: rtl/vga_tile_renderer.sv
// Tile-map VGA renderer: walks the tile grid with divider-free counters,
// fetches one cell code per pixel from a synchronous-read memory and
// colours it through the palette or a frame-latched game-over overlay.
// tile_addr leads the raster by one cycle so colour lands two cycles
// after the pixel's counter position, aligned with the delayed syncs.
module vga_tile_renderer
    import bombman_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int GRID_COLS = 10,
    parameter int GRID_ROWS = 10,
    parameter int TILE_W    = 64,
    parameter int TILE_H    = 48,
    parameter int CODE_W    = 3,
    parameter int ADDR_W    = $clog2(GRID_COLS * GRID_ROWS)
) (
    input  logic              pixel_clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] tile_addr,
    input  logic [CODE_W-1:0] tile_code,
    input  logic [1:0]        game_over,
    output logic              hsync,
    output logic              vsync,
    output logic [2:0]        red,
    output logic [2:0]        green,
    output logic [1:0]        blue,
    output logic              active,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int SX_W    = $clog2(TILE_W + 1);
    localparam int SY_W    = $clog2(TILE_H + 1);
    localparam int COL_W   = $clog2(GRID_COLS + 1);
    localparam int ROW_W   = $clog2(GRID_ROWS + 1);

    logic hsync_raw, vsync_raw, active_raw, line_end, frame_end, origin;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HC_W     (HC_W),
        .VC_W     (VC_W)
    ) u_timing (
        .pixel_clk_i  (pixel_clk),
        .rst_i        (rst),
        .hsync_raw_o  (hsync_raw),
        .vsync_raw_o  (vsync_raw),
        .active_raw_o (active_raw),
        .line_end_o   (line_end),
        .frame_end_o  (frame_end),
        .origin_o     (origin)
    );

    // Stage 0: tile counters for the current pixel and their next values
    logic [SX_W-1:0]   sub_x_q, sub_x_d;
    logic [SY_W-1:0]   sub_y_q, sub_y_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] tile_addr_q, addr_d;
    logic              in_grid_q, in_grid_d;
    logic [1:0]        mode_q;

    assign in_grid_q = (int'(col_q) < GRID_COLS) && (int'(row_q) < GRID_ROWS);
    assign in_grid_d = (int'(col_d) < GRID_COLS) && (int'(row_d) < GRID_ROWS);
    assign addr_d    = ADDR_W'(int'(row_d) * GRID_COLS + int'(col_d));
    assign tile_addr = tile_addr_q;

    // Advance sub-pixel/tile counters alongside hc/vc; tile indices saturate past the grid
    always_comb begin
        sub_x_d = sub_x_q + SX_W'(1);
        col_d   = col_q;
        sub_y_d = sub_y_q;
        row_d   = row_q;
        if (line_end) begin
            sub_x_d = '0;
            col_d   = '0;
            if (frame_end) begin
                sub_y_d = '0;
                row_d   = '0;
            end else if (sub_y_q == SY_W'(TILE_H - 1)) begin
                sub_y_d = '0;
                if (row_q != ROW_W'(GRID_ROWS)) row_d = row_q + ROW_W'(1);
            end else begin
                sub_y_d = sub_y_q + SY_W'(1);
            end
        end else if (sub_x_q == SX_W'(TILE_W - 1)) begin
            sub_x_d = '0;
            if (col_q != COL_W'(GRID_COLS)) col_d = col_q + COL_W'(1);
        end
    end

    // Tile counters, look-ahead tile address (held outside the grid) and frame-latched mode
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            sub_x_q     <= '0;
            sub_y_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            tile_addr_q <= '0;
            mode_q      <= GO_PLAYING;
        end else begin
            sub_x_q <= sub_x_d;
            sub_y_q <= sub_y_d;
            col_q   <= col_d;
            row_q   <= row_d;
            if (in_grid_d) tile_addr_q <= addr_d;
            if (origin)    mode_q      <= game_over;
        end
    end

    // Stage 1: control delayed one cycle while the cell code is read
    logic hsync_p1, vsync_p1, active_p1, in_grid_p1, fs_p1, checker_p1;

    // First delay stage for sync, visibility, grid and frame markers
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            hsync_p1   <= 1'b1;
            vsync_p1   <= 1'b1;
            active_p1  <= 1'b0;
            in_grid_p1 <= 1'b0;
            fs_p1      <= 1'b0;
        end else begin
            hsync_p1   <= hsync_raw;
            vsync_p1   <= vsync_raw;
            active_p1  <= active_raw;
            in_grid_p1 <= in_grid_q;
            fs_p1      <= origin;
        end
    end

    // Checkerboard parity travels with the pixel; pure data, no reset needed
    always_ff @(posedge pixel_clk) begin
        checker_p1 <= col_q[0] ^ row_q[0];
    end

    // Stage 2: colour selection and registered outputs
    logic [7:0] rgb_d, rgb_q;
    logic       hsync_q, vsync_q, active_q, fs_q;

    // Border and blanking are black; otherwise palette or overlay by latched mode
    always_comb begin
        rgb_d = RGB_BLACK;
        if (active_p1 && in_grid_p1) begin
            case (mode_q)
                GO_PLAYING: rgb_d = palette_rgb(3'(tile_code));
                GO_P1_WIN:  rgb_d = RGB_RED;
                GO_P2_WIN:  rgb_d = RGB_BLUE;
                default:    rgb_d = checker_p1 ? RGB_WHITE : RGB_BLACK;
            endcase
        end
    end

    // Output registers, colour aligned with the twice-delayed control
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            rgb_q    <= RGB_BLACK;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            active_q <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            rgb_q    <= rgb_d;
            hsync_q  <= hsync_p1;
            vsync_q  <= vsync_p1;
            active_q <= active_p1;
            fs_q     <= fs_p1;
        end
    end

    assign red         = rgb_q[7:5];
    assign green       = rgb_q[4:2];
    assign blue        = rgb_q[1:0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Bench for vga_tile_renderer: default-size instance checked against a
// per-pixel scoreboard, small-grid instance checked with a vector table
// and hand sequences for mode latching and mid-frame reset.
module tb_vga_tile_renderer;

    localparam logic [11:0] IDLE = 12'hC00; // hs=1 vs=1 act=0 fs=0 rgb=0
    localparam int NLINES = 50;
    localparam int S_HT   = 22;
    localparam int S_FRAME = 22 * 14;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    // Default-parameter instance
    logic       rst_d;
    logic [6:0] addr_d;
    logic [2:0] code_d;
    logic [1:0] go_d;
    logic       hs_d, vs_d, act_d, fs_d;
    logic [2:0] r_d, g_d;
    logic [1:0] b_d;
    logic [11:0] out_d;
    assign out_d = {hs_d, vs_d, act_d, fs_d, r_d, g_d, b_d};

    vga_tile_renderer dut (
        .pixel_clk(clk), .rst(rst_d), .tile_addr(addr_d), .tile_code(code_d),
        .game_over(go_d), .hsync(hs_d), .vsync(vs_d), .red(r_d), .green(g_d),
        .blue(b_d), .active(act_d), .frame_start(fs_d)
    );

    // Small-grid instance
    logic       rst_s;
    logic [2:0] addr_s;
    logic [2:0] code_s;
    logic [1:0] go_s;
    logic       hs_s, vs_s, act_s, fs_s;
    logic [2:0] r_s, g_s;
    logic [1:0] b_s;
    logic [11:0] out_s;
    logic [7:0]  rgb_s;
    assign out_s = {hs_s, vs_s, act_s, fs_s, r_s, g_s, b_s};
    assign rgb_s = {r_s, g_s, b_s};

    vga_tile_renderer #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(2),
        .GRID_COLS(3), .GRID_ROWS(2), .TILE_W(4), .TILE_H(2),
        .CODE_W(3), .ADDR_W(3)
    ) dut_s (
        .pixel_clk(clk), .rst(rst_s), .tile_addr(addr_s), .tile_code(code_s),
        .game_over(go_s), .hsync(hs_s), .vsync(vs_s), .red(r_s), .green(g_s),
        .blue(b_s), .active(act_s), .frame_start(fs_s)
    );

    // Synchronous-read game-state memories
    logic [2:0] mem_d [0:127];
    logic [2:0] mem_s [0:7];
    always @(posedge clk) begin
        code_d <= mem_d[addr_d];
        code_s <= mem_s[addr_s];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pal_m(input logic [2:0] c);
        case (c)
            3'd0: return 8'hFF;
            3'd1: return 8'hDF;
            3'd2: return 8'hBF;
            3'd3: return 8'h9F;
            3'd4: return 8'h7F;
            3'd5: return 8'h5F;
            3'd6: return 8'h3F;
            default: return 8'h00;
        endcase
    endfunction

    // Expected default-instance outputs for pixel (h,v) in playing mode
    function automatic logic [11:0] exp_def(input int h, input int v);
        logic hs, vs, act, fs;
        logic [7:0] rgb;
        int idx;
        act = (h < 640) && (v < 480);
        hs  = !((h >= 656) && (h < 752));
        vs  = !((v >= 490) && (v < 492));
        fs  = (h == 0) && (v == 0);
        rgb = 8'h00;
        if (act && (h / 64 < 10) && (v / 48 < 10)) begin
            idx = (v / 48) * 10 + h / 64;
            rgb = pal_m(mem_d[idx]);
        end
        return {hs, vs, act, fs, rgb};
    endfunction

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs_s && n < 2 * S_FRAME);
        if (!fs_s) chk("fs_timeout", 0, 1);
    endtask

    typedef struct {
        logic [1:0] go;
        int         x;
        int         y;
        logic [7:0] rgb;
    } vec_t;
    vec_t tbl [20];

    logic [11:0] sbq [$];
    logic [11:0] expv;
    int h, v, m_addr;
    int prev_hs, fall0, fall1, nfall, width0, run4;
    int pos, vs_first, vs_cnt, hs_first, hs_cnt, amax;
    logic [7:0] aseen;

    initial begin
        #4000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{2'd0, 0, 0, 8'hFF};
        tbl[1]  = '{2'd0, 5, 0, 8'hDF};
        tbl[2]  = '{2'd0, 9, 1, 8'hBF};
        tbl[3]  = '{2'd0, 0, 2, 8'h9F};
        tbl[4]  = '{2'd0, 6, 3, 8'h7F};
        tbl[5]  = '{2'd0, 11, 3, 8'h5F};
        tbl[6]  = '{2'd0, 12, 1, 8'h00};
        tbl[7]  = '{2'd0, 3, 4, 8'h00};
        tbl[8]  = '{2'd0, 15, 7, 8'h00};
        tbl[9]  = '{2'd1, 2, 1, 8'hE0};
        tbl[10] = '{2'd1, 13, 2, 8'h00};
        tbl[11] = '{2'd1, 5, 6, 8'h00};
        tbl[12] = '{2'd2, 7, 3, 8'h03};
        tbl[13] = '{2'd2, 14, 0, 8'h00};
        tbl[14] = '{2'd3, 0, 0, 8'h00};
        tbl[15] = '{2'd3, 4, 0, 8'hFF};
        tbl[16] = '{2'd3, 4, 2, 8'h00};
        tbl[17] = '{2'd3, 1, 3, 8'hFF};
        tbl[18] = '{2'd3, 8, 2, 8'hFF};
        tbl[19] = '{2'd3, 12, 3, 8'h00};

        for (int i = 0; i < 128; i++) mem_d[i] = 3'((i * 3) % 7);
        mem_d[13] = 3'd4;
        mem_d[14] = 3'd7;
        for (int i = 0; i < 8; i++) mem_s[i] = (i < 6) ? 3'(i) : 3'd0;

        rst_d = 1'b1; rst_s = 1'b1; go_d = 2'd0; go_s = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_out_d", int'(out_d), int'(IDLE));
        chk("rst_addr_d", int'(addr_d), 0);
        chk("rst_out_s", int'(out_s), int'(IDLE));
        chk("rst_addr_s", int'(addr_s), 0);

        // Default instance: per-pixel scoreboard over the first lines
        rst_d = 1'b0;
        sbq.push_back(IDLE);
        sbq.push_back(exp_def(0, 0));
        m_addr = 0; prev_hs = 1; nfall = 0; fall0 = -1; fall1 = -1; width0 = -1; run4 = 0;
        for (int j = 1; j <= NLINES * 800; j++) begin
            @(negedge clk);
            h = j % 800;
            v = j / 800;
            sbq.push_back(exp_def(h, v));
            expv = sbq.pop_front();
            chk("sb_pixel", int'(out_d), int'(expv));
            if ((h < 640) && (v < 480)) m_addr = (v / 48) * 10 + h / 64;
            chk("sb_addr", int'(addr_d), m_addr);
            if (prev_hs == 1 && hs_d == 1'b0) begin
                if (nfall == 0) fall0 = j;
                if (nfall == 1) fall1 = j;
                nfall++;
            end
            if (prev_hs == 0 && hs_d == 1'b1 && width0 < 0) width0 = j - fall0;
            prev_hs = int'(hs_d);
            if (j == 48 * 800)       chk("addr_line48_start", int'(addr_d), 10);
            if (j == 48 * 800 + 192) chk("addr_13", int'(addr_d), 13);
            if (j == 48 * 800 + 193) chk("code4_not_yet", int'({r_d, g_d, b_d}), 8'hDF);
            if (j == 48 * 800 + 194) chk("code4_lat2", int'({r_d, g_d, b_d}), 8'h7F);
            if (j == 48 * 800 + 258) chk("code7_black", int'({r_d, g_d, b_d}), 8'h00);
            if (v == 48 && {r_d, g_d, b_d} == 8'h7F) run4++;
        end
        chk("hs_first_fall", fall0, 658);
        chk("hs_low_width", width0, 96);
        chk("line_period", fall1 - fall0, 800);
        chk("code4_run", run4, 64);

        // Small instance: first frame_start and whole-frame structure
        rst_s = 1'b0;
        pos = -1;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (fs_s && pos < 0) pos = j;
        end
        chk("s_fs_first", pos, 2);
        wait_fs();
        vs_first = -1; vs_cnt = 0; hs_first = -1; hs_cnt = 0; amax = 0; aseen = '0;
        for (int k = 0; k < S_FRAME; k++) begin
            if (k > 0) @(negedge clk);
            if (!vs_s) begin
                if (vs_first < 0) vs_first = k;
                vs_cnt++;
            end
            if (!hs_s) begin
                if (hs_first < 0) hs_first = k;
                hs_cnt++;
            end
            if (int'(addr_s) > amax) amax = int'(addr_s);
            aseen[addr_s] = 1'b1;
        end
        @(negedge clk);
        chk("s_frame_period", int'(fs_s), 1);
        chk("s_vs_first", vs_first, 10 * S_HT);
        chk("s_vs_len", vs_cnt, 2 * S_HT);
        chk("s_hs_first", hs_first, 18);
        chk("s_hs_count", hs_cnt, 2 * 14);
        chk("s_addr_max", amax, 5);
        chk("s_addr_seen", int'(aseen), 8'h3F);

        // Table of pixel vectors; mode changes need a full frame to take hold
        for (int i = 0; i < 20; i++) begin
            if (tbl[i].go != go_s) begin
                go_s = tbl[i].go;
                wait_fs();
            end
            wait_fs();
            repeat (tbl[i].y * S_HT + tbl[i].x) @(negedge clk);
            chk($sformatf("vec%0d", i), int'(rgb_s), int'(tbl[i].rgb));
        end

        // Mid-frame game_over change must not tear the current frame
        go_s = 2'd0;
        wait_fs();
        wait_fs();
        repeat (2 * S_HT) @(negedge clk);
        go_s = 2'd1;
        repeat (S_HT + 1) @(negedge clk);
        chk("latch_same_frame", int'(rgb_s), 8'h9F);
        wait_fs();
        repeat (S_HT + 1) @(negedge clk);
        chk("latch_next_frame", int'(rgb_s), 8'hE0);

        // Asynchronous reset in the middle of a frame
        wait_fs();
        repeat (5 * S_HT + 10) @(negedge clk);
        #5;
        rst_s = 1'b1;
        #1;
        chk("midrst_out", int'(out_s), int'(IDLE));
        chk("midrst_addr", int'(addr_s), 0);
        @(negedge clk);
        chk("midrst_hold", int'(out_s), int'(IDLE));
        rst_s = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (j == 1) chk("midrst_fs_j1", int'(fs_s), 0);
            if (j == 2) chk("midrst_fs_j2", int'(fs_s), 1);
            if (j == 2) chk("midrst_rgb_j2", int'(rgb_s), 8'hE0);
            if (j == 3) chk("midrst_addr_j3", int'(addr_s), 0);
            if (j == 4) chk("midrst_addr_j4", int'(addr_s), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
